nibble_serial_sub: RTL
======================

# nibble_serial_sub

Multi-cycle WIDTH-bit subtractor that computes a − b − bin one 4-bit slice per clock. It reuses 4-bit carry-lookahead slice logic in inverted form: subtraction is a + ~b + ~borrow. It sits beside the combinational 4-bit CLA adder in the arithmetic library and is its inverse-direction counterpart. It serves datapaths that need wide subtraction at low area and can tolerate multi-cycle latency. Operands are captured under a start/busy/done handshake.

## Interface
- WIDTH, 16: operand width in bits. Must be a multiple of 4 and ≥ 4. N = WIDTH/4 slices.
- clk  input  1  sole clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request a new subtraction. Accepted only in IDLE.
- a  input  WIDTH  minuend, sampled on the accepting edge.
- b  input  WIDTH  subtrahend, sampled on the accepting edge.
- bin  input  1  borrow-in, sampled on the accepting edge.
- busy  output  1  high while slices are being processed.
- done  output  1  one-cycle pulse when the result is valid.
- diff  output  WIDTH  result, (a − b − bin) mod 2^WIDTH.
- bout  output  1  borrow-out: 1 when a < b + bin (unsigned).
- ovf  output  1  signed two's-complement overflow (see Configuration).

## Operation
- States are IDLE, RUN and DONE. Reset state is IDLE.
- IDLE → RUN: on an edge with start=1. Latch a, b and bin into internal registers. Clear the slice index to 0. Set the borrow register to bin. Clear diff, bout and ovf to 0.
- RUN: each edge processes slice k = index, bits [4k+3:4k].
  - Slice math: {c, s} = a_k + ~b_k + ~borrow, using 4-bit generate/propagate lookahead (g = a&~b, p = a^~b).
  - Write s into diff[4k+3:4k].
  - Next borrow = ~c.
  - Increment the index.
- RUN → DONE: on the edge that processes slice N−1. On that edge, bout ← final borrow and ovf is computed.
- DONE → IDLE: unconditionally on the next edge.
- start is ignored in RUN and in DONE. A request is never queued.
- diff, bout and ovf hold their values from DONE until the next accepted start.
- Operand inputs may change freely after the accepting edge. Only the latched copies are used.

## Timing
- Reset values: busy=0, done=0, diff=0, bout=0, ovf=0, state=IDLE. Reset takes effect immediately, without waiting for a clock edge.
- Reset during RUN or DONE aborts the operation. No done pulse is produced for the aborted operation.
- Latency: call the accepting edge E0.
  - busy is 1 from E0 until edge E_N.
  - done=1 for exactly the cycle between E_N and E_{N+1}.
  - For WIDTH=16, done is high in the 5th cycle after E0.
- Throughput: one operation per N+2 cycles. A start held high continuously is accepted again on the first edge after DONE returns to IDLE.
- busy and done are never high together.
- diff bits for slices not yet processed read 0 while busy. Only the value qualified by done is architectural.

## Configuration
- SUB_OVF_EN defined:
  - ovf = (a[W−1] ≠ b[W−1]) & (diff[W−1] ≠ a[W−1]), using the latched operands and the final diff.
  - ovf is registered together with bout at E_N.
- SUB_OVF_EN undefined: ovf is constant 0 and no overflow logic is built.

## Test plan
- WIDTH=16, a=0x0005, b=0x0003, bin=0, one-cycle start: busy is high for 4 cycles, then done pulses once, with diff=0x0002, bout=0 and ovf=0.
- a=0x0000, b=0x0001, bin=0 → diff=0xFFFF, bout=1, ovf=0. Checks a borrow that ripples across all 4 slices.
- a=0x8000, b=0x0001, bin=0 → diff=0x7FFF, bout=0. ovf=1 with SUB_OVF_EN defined, ovf=0 without it.
- a=0x1234, b=0x1234, bin=1 → diff=0xFFFF, bout=1, ovf=0.
- Second start pulse with a=0xFFFF at the 2nd busy cycle → ignored. The first result is unchanged, and exactly one done pulse occurs per accepted start.
- Assert rst asynchronously at the 3rd busy cycle → busy, done, diff, bout and ovf go to 0 immediately, with no done pulse. A fresh start afterwards (a=0x00F0, b=0x000F) → diff=0x00E1, bout=0.

Source files
------------

// File: rtl/sub_if.sv
// sub_if: operand/result bus with start/busy/done handshake for nibble_serial_sub
// Signals: start, a, b, bin (requester to subtractor); busy, done, diff, bout, ovf (subtractor to requester).
// The master modport is the requester side and the slave modport is the subtractor side.
interface sub_if #(parameter int WIDTH = 16);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             ovf;
    modport master (output start, a, b, bin, input busy, done, diff, bout, ovf);
    modport slave  (input start, a, b, bin, output busy, done, diff, bout, ovf);
endinterface

// File: rtl/nibble_serial_sub.sv
// nibble_serial_sub: computes a - b - bin one 4-bit lookahead slice per clock.
// Ports: clk, rst (async, active-high), bus (sub_if.slave).
//   bus.start/a/b/bin are sampled when a request is accepted in IDLE.
//   bus.busy is high while slices run, and bus.done pulses for one cycle with the result.
//   bus.diff/bout/ovf hold the result until the next accepted start.
// Macro SUB_OVF_EN builds the signed-overflow flag. Without it, ovf is tied to 0.
module nibble_serial_sub #(parameter int WIDTH = 16) (
    input  logic  clk,
    input  logic  rst,
    sub_if.slave  bus
);
    localparam int N  = WIDTH / 4;
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t           r_state, w_next;
    logic [WIDTH-1:0] r_a, r_b, r_diff;
    logic [IW-1:0]    r_idx;
    logic             r_borrow, r_bout;
    logic             w_accept, w_last, w_cin;
    logic [3:0]       w_sa, w_sb, w_g, w_p, w_s;
    logic [4:0]       w_c;
    assign w_accept = (r_state == IDLE) && bus.start;
    assign w_last   = (r_state == RUN) && (r_idx == IW'(N - 1));
    // Subtraction as addition: a + ~b + ~borrow, carry-out is the inverted borrow.
    assign w_sa  = r_a[4*r_idx +: 4];
    assign w_sb  = ~r_b[4*r_idx +: 4];
    assign w_g   = w_sa & w_sb;
    assign w_p   = w_sa ^ w_sb;
    assign w_cin = ~r_borrow;
    assign w_c   = {w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1]) | (w_p[3] & w_p[2] & w_p[1] & w_g[0]) | (&w_p & w_cin),
                    w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0]) | (w_p[2] & w_p[1] & w_p[0] & w_cin),
                    w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & w_cin),
                    w_g[0] | (w_p[0] & w_cin),
                    w_cin};
    assign w_s   = w_p ^ w_c[3:0];
    always_comb begin
        w_next = w_accept ? RUN : w_last ? DONE : (r_state == RUN) ? RUN : IDLE;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_a      <= '0;
            r_b      <= '0;
            r_diff   <= '0;
            r_idx    <= '0;
            r_borrow <= 1'b0;
            r_bout   <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_a      <= bus.a;
                r_b      <= bus.b;
                r_borrow <= bus.bin;
                r_idx    <= '0;
                r_diff   <= '0;
                r_bout   <= 1'b0;
            end else if (r_state == RUN) begin
                r_diff[4*r_idx +: 4] <= w_s;
                r_borrow             <= ~w_c[4];
                r_idx                <= r_idx + IW'(1);
                if (w_last) r_bout <= ~w_c[4];
            end
        end
    end
    assign bus.busy = (r_state == RUN);
    assign bus.done = (r_state == DONE);
    assign bus.diff = r_diff;
    assign bus.bout = r_bout;
`ifdef SUB_OVF_EN
    logic r_ovf;
    // The final slice's sum bit 3 is the result sign bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_ovf <= 1'b0;
        else if (w_accept) r_ovf <= 1'b0;
        else if (w_last) r_ovf <= (r_a[WIDTH-1] ^ r_b[WIDTH-1]) & (w_s[3] ^ r_a[WIDTH-1]);
    end
    assign bus.ovf = r_ovf;
`else
    assign bus.ovf = 1'b0;
`endif
endmodule
